// File: rtl/mshr_pkg.sv
// -----------------------------------------------------------------------------
// mshr_pkg
// Shared definitions for the single-entry MSHR with victim write-back buffer:
// line geometry constants, the controller state encoding and a helper that
// extracts one word from a packed cache line.
// -----------------------------------------------------------------------------
package mshr_pkg;

   localparam int WORD_WIDTH        = 32;
   localparam int ADR_WIDTH         = 32;
   localparam int WORD_NUM          = 4;
   localparam int WORD_OFFSET_WIDTH = 2;
   localparam int DATAMEM_WIDTH     = WORD_WIDTH * WORD_NUM;
   localparam int LINE_ADR_WIDTH    = ADR_WIDTH - WORD_OFFSET_WIDTH - 2;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FILL  = 2'b01,
      DRAIN = 2'b10
   } mshr_state_e;

   // Word idx of a line; word k lives in bits [32k+31:32k].
   function automatic logic [WORD_WIDTH-1:0] word_slice(
      input logic [DATAMEM_WIDTH-1:0]     line,
      input logic [WORD_OFFSET_WIDTH-1:0] idx
   );
      return line[int'(idx)*WORD_WIDTH +: WORD_WIDTH];
   endfunction

endpackage

// File: rtl/mshr_line_buf.sv
// -----------------------------------------------------------------------------
// mshr_line_buf
// Refill line assembly buffer. Words arrive in any order and are written into
// their slot; a per-word mask tracks which slots have been filled.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   clr            clear the fill mask (new allocation)
//   wr_en          write wr_dat into slot wr_idx
//   wr_idx, wr_dat slot index and word
//   line           assembled line (held until overwritten)
//   mask           per-slot filled flags
//   complete       this write fills the last empty slot
// -----------------------------------------------------------------------------
module mshr_line_buf
   import mshr_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         wr_en,
   input  logic [WORD_OFFSET_WIDTH-1:0] wr_idx,
   input  logic [WORD_WIDTH-1:0]        wr_dat,
   output logic [DATAMEM_WIDTH-1:0]     line,
   output logic [WORD_NUM-1:0]          mask,
   output logic                         complete
);

   logic [DATAMEM_WIDTH-1:0] line_q, line_d;
   logic [WORD_NUM-1:0]      mask_q, mask_d;
   logic [WORD_NUM-1:0]      idx_onehot;

   always_comb begin
      idx_onehot         = '0;
      idx_onehot[wr_idx] = 1'b1;
   end

   // The incoming word counts toward completion in the same cycle, so a
   // repeated index leaves the mask unchanged and cannot complete the line.
   assign complete = wr_en && ((mask_q | idx_onehot) == {WORD_NUM{1'b1}});

   always_comb begin
      line_d = line_q;
      mask_d = mask_q;
      if (clr) begin
         mask_d = '0;
      end else if (wr_en) begin
         line_d[int'(wr_idx)*WORD_WIDTH +: WORD_WIDTH] = wr_dat;
         mask_d = mask_q | idx_onehot;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line_q <= '0;
         mask_q <= '0;
      end else begin
         line_q <= line_d;
         mask_q <= mask_d;
      end
   end

   assign line = line_q;
   assign mask = mask_q;

endmodule

// File: rtl/mshr_writeback.sv
// -----------------------------------------------------------------------------
// mshr_writeback
// Single-entry miss status holding register. On allocate it captures the
// victim line and both line addresses, assembles the refill line from memory
// words arriving in any order, reports it with fill_done, and if the victim
// was dirty drains it word by word to memory over a req/ack handshake.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   alloc_cc2mshr                 allocate pulse (ignored while busy)
//   dat/vadr/vdirty/radr_cc2mshr  victim line, victim addr, dirty, refill addr
//   fvalid/dat/word_mem2mshr      refill word stream
//   busy_mshr2cc                  entry occupied
//   fill_done_mshr2cc             refill complete pulse
//   fill_line/fill_adr_mshr2cc    assembled refill line and its address
//   req/we/adr/dat_mshr2mem       victim write-back request
//   ack_mem2mshr                  write-back word accepted
//   wb_done_mshr2cc               last victim word accepted pulse
// -----------------------------------------------------------------------------
module mshr_writeback
   import mshr_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alloc_cc2mshr,
   input  logic [DATAMEM_WIDTH-1:0]     dat_cc2mshr,
   input  logic [LINE_ADR_WIDTH-1:0]    vadr_cc2mshr,
   input  logic                         vdirty_cc2mshr,
   input  logic [LINE_ADR_WIDTH-1:0]    radr_cc2mshr,
   input  logic                         fvalid_mem2mshr,
   input  logic [WORD_WIDTH-1:0]        dat_mem2mshr,
   input  logic [WORD_OFFSET_WIDTH-1:0] word_mem2mshr,
   output logic                         busy_mshr2cc,
   output logic                         fill_done_mshr2cc,
   output logic [DATAMEM_WIDTH-1:0]     fill_line_mshr2cc,
   output logic [LINE_ADR_WIDTH-1:0]    fill_adr_mshr2cc,
   output logic                         req_mshr2mem,
   output logic                         we_mshr2mem,
   output logic [ADR_WIDTH-1:0]         adr_mshr2mem,
   output logic [WORD_WIDTH-1:0]        dat_mshr2mem,
   input  logic                         ack_mem2mshr,
   output logic                         wb_done_mshr2cc
);

   localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_WORD = WORD_OFFSET_WIDTH'(WORD_NUM - 1);

   mshr_state_e                  state_q, state_d;
   logic [DATAMEM_WIDTH-1:0]     victim_q, victim_d;
   logic [LINE_ADR_WIDTH-1:0]    vadr_q, vadr_d;
   logic                         vdirty_q, vdirty_d;
   logic [LINE_ADR_WIDTH-1:0]    radr_q, radr_d;
   logic [WORD_OFFSET_WIDTH-1:0] cnt_q, cnt_d;
   logic                         busy_q, busy_d;
   logic                         req_q, req_d;
   logic                         fill_done_q, fill_done_d;
   logic                         wb_done_q, wb_done_d;

   logic                         alloc_take;
   logic                         fill_wr;
   logic                         fill_complete;
   logic [WORD_NUM-1:0]          fill_mask;

   // Decoded straight from the registered state so the line buffer's
   // completion flag never loops back through the next-state logic.
   assign alloc_take = alloc_cc2mshr && (state_q == IDLE);
   assign fill_wr    = fvalid_mem2mshr && (state_q == FILL);

   mshr_line_buf u_line_buf (
      .clk      (clk),
      .rst      (rst),
      .clr      (alloc_take),
      .wr_en    (fill_wr),
      .wr_idx   (word_mem2mshr),
      .wr_dat   (dat_mem2mshr),
      .line     (fill_line_mshr2cc),
      .mask     (fill_mask),
      .complete (fill_complete)
   );

   // Next-state and registered-output logic. Pulses default low so they last
   // exactly one cycle; req/busy are level outputs carried in flops.
   always_comb begin
      state_d     = state_q;
      victim_d    = victim_q;
      vadr_d      = vadr_q;
      vdirty_d    = vdirty_q;
      radr_d      = radr_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      req_d       = req_q;
      fill_done_d = 1'b0;
      wb_done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (alloc_take) begin
               victim_d = dat_cc2mshr;
               vadr_d   = vadr_cc2mshr;
               vdirty_d = vdirty_cc2mshr;
               radr_d   = radr_cc2mshr;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = FILL;
            end
         end
         FILL: begin
            if (fill_complete) begin
               fill_done_d = 1'b1;
               if (vdirty_q) begin
                  state_d = DRAIN;
                  cnt_d   = '0;
                  req_d   = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         DRAIN: begin
            if (req_q && ack_mem2mshr) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_WORD) begin
                  state_d   = IDLE;
                  busy_d    = 1'b0;
                  req_d     = 1'b0;
                  wb_done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         victim_q    <= '0;
         vadr_q      <= '0;
         vdirty_q    <= 1'b0;
         radr_q      <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         req_q       <= 1'b0;
         fill_done_q <= 1'b0;
         wb_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         victim_q    <= victim_d;
         vadr_q      <= vadr_d;
         vdirty_q    <= vdirty_d;
         radr_q      <= radr_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         req_q       <= req_d;
         fill_done_q <= fill_done_d;
         wb_done_q   <= wb_done_d;
      end
   end

   // Address and data come straight from the held registers, so they stay
   // stable for as long as memory withholds ack. Zero when not requesting.
   assign busy_mshr2cc      = busy_q;
   assign fill_done_mshr2cc = fill_done_q;
   assign fill_adr_mshr2cc  = radr_q;
   assign req_mshr2mem      = req_q;
   assign we_mshr2mem       = req_q;
   assign adr_mshr2mem      = req_q ? {vadr_q, cnt_q, 2'b00} : '0;
   assign dat_mshr2mem      = req_q ? word_slice(victim_q, cnt_q) : '0;
   assign wb_done_mshr2cc   = wb_done_q;

endmodule
